// File: rtl/sdes_pkg.sv
// -----------------------------------------------------------------------------
// sdes_pkg
// Shared constants for the S-DES substitution datapath.
//   S1_TABLE   : S-DES S1 box, 16 entries of 2 bits (entry i = S1_TABLE[i]).
//   TBL_MAX_W  : largest flattened table image table_init can build.
//   table_init : returns the reset image of a lookup table as a flat vector,
//                entry i occupying bits [i*out_w +: out_w].
// -----------------------------------------------------------------------------
package sdes_pkg;

    localparam int TBL_MAX_W = 1024;

    // Packed so that S1_TABLE[i] is entry i: 0,2,1,0,2,1,3,3,3,2,0,1,1,0,0,3.
    localparam logic [15:0][1:0] S1_TABLE = {
        2'd3, 2'd0, 2'd0, 2'd1, 2'd1, 2'd0, 2'd2, 2'd3,
        2'd3, 2'd3, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0
    };

    // init_sel 0 gives an all-zero image; init_sel 1 gives S1 (only meaningful
    // for a 16 x 2-bit table, which the instantiating module enforces).
    function automatic logic [TBL_MAX_W-1:0] table_init(input int init_sel,
                                                        input int in_w,
                                                        input int out_w);
        logic [TBL_MAX_W-1:0] img;
        img = '0;
        if (init_sel == 1 && in_w == 4 && out_w == 2) begin
            for (int i = 0; i < 16; i++) begin
                img[i*2 +: 2] = S1_TABLE[i];
            end
        end
        return img;
    endfunction

endpackage

// File: rtl/sbox_lane_rd.sv
// -----------------------------------------------------------------------------
// sbox_lane_rd
// Combinational single-lane table read: val = tbl[idx].
//   tbl : full lookup table, 2**IN_W entries of OUT_W bits
//   idx : IN_W-bit index for this lane
//   val : OUT_W-bit table entry selected by idx
// -----------------------------------------------------------------------------
module sbox_lane_rd #(
    parameter int IN_W  = 4,
    parameter int OUT_W = 2
) (
    input  logic [OUT_W-1:0] tbl [2**IN_W],
    input  logic [IN_W-1:0]  idx,
    output logic [OUT_W-1:0] val
);

    assign val = tbl[idx];

endmodule

// File: rtl/sbox_lookup_pipe.sv
// -----------------------------------------------------------------------------
// sbox_lookup_pipe
// Multi-lane, two-stage, stallable S-box lookup with a runtime-writable table.
//   i_clk, i_rst_n      : clock, asynchronous active-low reset
//   i_valid / o_ready   : input handshake, i_data holds LANES IN_W-bit indices
//   o_valid / i_ready   : output handshake, o_data holds LANES OUT_W-bit results
//   i_wr_en/addr/data   : table write port, takes effect at the clock edge
//   o_count             : completed output handshakes, wraps at 2**16
// Stage A registers the indices; stage B reads the table and registers the
// results into o_data. A write on the same edge as the stage B read is not
// seen by that read.
// -----------------------------------------------------------------------------
module sbox_lookup_pipe
    import sdes_pkg::*;
#(
    parameter int IN_W     = 4,
    parameter int OUT_W    = 2,
    parameter int LANES    = 2,
    parameter int INIT_SEL = 1
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic [LANES*IN_W-1:0]  i_data,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [LANES*OUT_W-1:0] o_data,
    input  logic                   i_wr_en,
    input  logic [IN_W-1:0]        i_wr_addr,
    input  logic [OUT_W-1:0]       i_wr_data,
    output logic [15:0]            o_count
);

    localparam int DEPTH = 2**IN_W;
    localparam logic [TBL_MAX_W-1:0] INIT_IMG = table_init(INIT_SEL, IN_W, OUT_W);

    generate
        if (INIT_SEL != 0 && INIT_SEL != 1) begin : g_bad_sel
            $error("sbox_lookup_pipe: INIT_SEL must be 0 or 1");
        end
        if (INIT_SEL == 1 && (IN_W != 4 || OUT_W != 2)) begin : g_bad_s1
            $error("sbox_lookup_pipe: INIT_SEL=1 requires IN_W=4 and OUT_W=2");
        end
        if (DEPTH * OUT_W > TBL_MAX_W) begin : g_bad_size
            $error("sbox_lookup_pipe: table image exceeds TBL_MAX_W");
        end
    endgenerate

    logic [OUT_W-1:0]       tbl [DEPTH];
    logic                   vld_p0;
    logic [LANES*IN_W-1:0]  idx_p0;
    logic [LANES*OUT_W-1:0] lut_p0;
    logic                   adv_a;
    logic                   adv_b;

    // Stage B drains when empty or consumed; stage A moves when empty or
    // when stage B moves, so a bubble in A never blocks new input.
    assign adv_b   = !o_valid || i_ready;
    assign adv_a   = !vld_p0 || adv_b;
    assign o_ready = adv_a;

    // Table flops: reload reset image, otherwise one write per cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                tbl[i] <= INIT_IMG[i*OUT_W +: OUT_W];
            end
        end else if (i_wr_en) begin
            tbl[i_wr_addr] <= i_wr_data;
        end
    end

    // ---- Stage A: index capture ----
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vld_p0 <= 1'b0;
        end else if (adv_a) begin
            vld_p0 <= i_valid;
        end
    end

    always_ff @(posedge i_clk) begin
        if (adv_a && i_valid) begin
            idx_p0 <= i_data;
        end
    end

    // ---- Stage B: table read and output register ----
    genvar k;
    generate
        for (k = 0; k < LANES; k++) begin : g_lane
            sbox_lane_rd #(
                .IN_W  (IN_W),
                .OUT_W (OUT_W)
            ) u_rd (
                .tbl (tbl),
                .idx (idx_p0[k*IN_W +: IN_W]),
                .val (lut_p0[k*OUT_W +: OUT_W])
            );
        end
    endgenerate

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid <= 1'b0;
            o_data  <= '0;
        end else if (adv_b) begin
            o_valid <= vld_p0;
            // Hold the last result across bubbles; only a real beat replaces it.
            if (vld_p0) begin
                o_data <= lut_p0;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_count <= 16'd0;
        end else if (o_valid && i_ready) begin
            o_count <= o_count + 16'd1;
        end
    end

endmodule
